// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the buck register-file SPI controller.
// Frame layout is {2'b00, data[9:0], addr[3:0]}, sent MSB first.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        TRAIL,
        GAP
    } state_e;

    localparam logic [3:0] REG_CTRL    = 4'd0;
    localparam logic [3:0] REG_DUTY_HI = 4'd1;
    localparam logic [3:0] REG_DUTY_LO = 4'd2;
    localparam logic [3:0] REG_FREQ    = 4'd3;
    localparam logic [3:0] REG_4       = 4'd4;
    localparam logic [3:0] REG_5       = 4'd5;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 3;
    localparam int DATA_LSB = 4;
    localparam int DATA_MSB = 13;

    function automatic logic [15:0] build_frame(
        input logic [3:0] addr,
        input logic [9:0] data
    );
        logic [15:0] f;
        f = '0;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_sck_div.sv
// SCK half-period timer: pulses tick every CLK_DIV clk cycles while enabled.
module spi_sck_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = (!en || tick) ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 initiator turning register-write requests into 16-bit frames
// and capturing the peripheral's CIPO reply.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int LENGTH_SEND  = 16,
    parameter int LENGTH_COUNT = 6,
    parameter int PAUSE        = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_addr,
    input  logic [9:0]             req_data,
    output logic                   rsp_valid,
    output logic [LENGTH_SEND-1:0] rsp_data,
    output logic                   busy,
    output logic                   SCK,
    output logic                   COPI,
    output logic                   CS,
    input  logic                   CIPO
);

    localparam logic [LENGTH_COUNT-1:0] LAST_BIT = LENGTH_COUNT'(LENGTH_SEND);
    localparam logic [15:0]             GAP_LAST = 16'(PAUSE - 1);

    state_e state_q, state_d;
    logic [LENGTH_SEND-1:0]  tx_q, tx_d;
    logic [LENGTH_SEND-1:0]  rx_q, rx_d;
    logic [LENGTH_SEND-1:0]  rsp_data_q, rsp_data_d;
    logic [LENGTH_COUNT-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]             gap_q, gap_d;
    logic cs_q, cs_d, sck_q, sck_d, copi_q, copi_d;
    logic rdy_q, rdy_d, busy_q, busy_d, rv_q, rv_d;
    logic tick, div_en;

    assign div_en = (state_q == SETUP) || (state_q == SCK_HI) ||
                    (state_q == SCK_LO) || (state_q == TRAIL);

    spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk (clk),
        .rst (rst),
        .en  (div_en),
        .tick(tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rsp_data_d = rsp_data_q;
        bit_cnt_d  = bit_cnt_q;
        gap_d      = gap_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        copi_d     = copi_q;
        rdy_d      = rdy_q;
        busy_d     = busy_q;
        rv_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // req_ready low in IDLE means a request was just latched.
                if (rdy_q) begin
                    if (req_valid) begin
                        tx_d  = LENGTH_SEND'(build_frame(req_addr, req_data));
                        rdy_d = 1'b0;
                    end
                end else begin
                    cs_d      = 1'b0;
                    copi_d    = tx_q[LENGTH_SEND-1];
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP, SCK_LO: begin
                if (tick) begin
                    sck_d     = 1'b1;
                    rx_d      = {rx_q[LENGTH_SEND-2:0], CIPO};
                    bit_cnt_d = bit_cnt_q + LENGTH_COUNT'(1);
                    state_d   = SCK_HI;
                end
            end
            SCK_HI: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = TRAIL;
                    end else begin
                        tx_d    = tx_q << 1;
                        copi_d  = tx_q[LENGTH_SEND-2];
                        state_d = SCK_LO;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    cs_d       = 1'b1;
                    copi_d     = 1'b0;
                    rv_d       = 1'b1;
                    rsp_data_d = rx_q;
                    gap_d      = '0;
                    if (PAUSE == 0) begin
                        busy_d  = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            rsp_data_q <= '0;
            bit_cnt_q  <= '0;
            gap_q      <= '0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            copi_q     <= 1'b0;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
            rv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rsp_data_q <= rsp_data_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_q      <= gap_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            copi_q     <= copi_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            rv_q       <= rv_d;
        end
    end

    assign req_ready = rdy_q;
    assign rsp_valid = rv_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign SCK       = sck_q;
    assign COPI      = copi_q;
    assign CS        = cs_q;

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI controller (initiator) for the buck register-file peripheral: turns parallel register-write requests into 16-bit SPI frames on SCK/COPI/CS.
- Captures the peripheral's CIPO reply of each frame.
- Sits in the test/host-side logic or on an on-chip supervisor that programmes mode, enable, duty_high, duty_low and freq_switch.
- Frame format: {2'b00, data[9:0], addr[3:0]}, MSB first, SPI mode 0. The peripheral samples COPI on SCK rising edges.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; legal range 1..255.
- LENGTH_SEND, 16: frame length in bits.
- LENGTH_COUNT, 6: bit-counter width; must satisfy 2**LENGTH_COUNT > LENGTH_SEND.
- PAUSE, 10: clk cycles CS stays high after a frame before the next frame may start.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  write request present.
- req_ready  output  1  controller can accept a request.
- req_addr  input  4  register address.
- req_data  input  10  register payload.
- rsp_valid  output  1  one-cycle pulse when a frame completes.
- rsp_data  output  LENGTH_SEND  bits captured from CIPO during the frame, MSB first.
- busy  output  1  high from request accept until end of PAUSE.
- SCK  output  1  SPI clock; idles low.
- COPI  output  1  controller-out data.
- CS  output  1  active-low chip select; idles high.
- CIPO  input  1  peripheral-out data.

Behaviour:
- Reset (async assert, sync release): CS=1, SCK=0, COPI=0, req_ready=1, busy=0, rsp_valid=0, rsp_data=0, all counters 0, state IDLE. Reset mid-frame aborts immediately with no rsp_valid.
- All outputs are registered. SCK is never glitched.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, TRAIL, GAP.
- IDLE:
  - req_ready=1.
  - A handshake is req_valid&&req_ready.
  - On handshake, latch tx_shift={2'b00,req_data,req_addr}.
  - Next cycle: CS=0, COPI=tx_shift[15], busy=1, enter SETUP.
  - req_ready=0 in every other state.
- SETUP: hold CLK_DIV cycles, then SCK=1 and enter SCK_HI.
- SCK_HI:
  - On the clk edge that raises SCK, shift CIPO into rx_shift LSB and increment bit_cnt.
  - Hold CLK_DIV cycles.
  - Then SCK=0.
  - If bit_cnt==LENGTH_SEND, enter TRAIL. Otherwise present the next tx bit on COPI on that same edge and enter SCK_LO.
- SCK_LO: hold CLK_DIV cycles, then SCK=1 and enter SCK_HI.
- TRAIL: hold CLK_DIV cycles with SCK=0, then, on the same edge:
  - CS=1, COPI=0.
  - rsp_valid=1 for exactly one cycle.
  - rsp_data=rx_shift.
  - Enter GAP.
- GAP: CS high for PAUSE cycles, then busy=0 and enter IDLE. PAUSE=0 goes straight to IDLE.
- Timing per frame:
  - Exactly LENGTH_SEND SCK rising edges.
  - CS low for (2*LENGTH_SEND+1)*CLK_DIV clk cycles; 33*CLK_DIV for 16 bits.
  - The next possible CS fall is PAUSE+2 cycles after CS rise.
- Addresses 6..15 are transmitted unmodified; filtering belongs to the peripheral.
- req_addr and req_data are sampled only at the handshake. Later changes have no effect on the frame in flight.
- rsp_data holds its value until the next frame completes.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum.
  - register address constants: REG_CTRL=0, REG_DUTY_HI=1, REG_DUTY_LO=2, REG_FREQ=3, REG_4=4, REG_5=5.
  - frame field positions: ADDR_LSB=0, ADDR_MSB=3, DATA_LSB=4, DATA_MSB=13.
  - frame-build function.
- One natural sub-module: spi_sck_div. It is the half-period counter that issues a tick every CLK_DIV cycles while enabled. FSM and shift registers stay in spi_reg_ctrl.

Test Plan:
1. CLK_DIV=2, write addr=1, data=10'h155 -> COPI sampled at SCK rises reads 16'h1551, 16 rising edges, CS low 66 clk, one rsp_valid pulse on CS rise.
2. Bench peripheral model shifts 16'hA5C3 on CIPO, changing on SCK falls -> rsp_data=16'hA5C3 with rsp_valid.
3. req_valid held high with two queued requests (addr 2/10'h0FF, addr 3/10'h200) -> frames 16'h0FF2 then 16'h2003, second CS fall PAUSE+2=12 clk after first CS rise, req_ready low throughout.
4. rst driven low after the 7th SCK rise -> same cycle CS=1, SCK=0, COPI=0, no rsp_valid; after release, req_ready=1 and a new write of addr 0/10'h003 sends 16'h0030 correctly.
5. addr=4'hF, data=10'h3FF -> frame 16'h3FFF sent unmodified.
6. CLK_DIV=1, loop back COPI->CIPO through a one-bit peripheral register model -> SCK period 2 clk, CS low 33 clk, rsp_data equals expected shifted pattern.
